// File: rtl/seq_detect_ctrl_if.sv
// Handshake bundle for seq_detect_ctrl: word input channel (producer side)
// and match-count result channel (consumer side).
interface seq_detect_ctrl_if #(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 5
);
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [CNT_W-1:0]  out_count;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Word-level controller that serializes words MSB-first into an overlapping
// "1101" Moore detector and returns the saturating match count per word.
// Optional sticky match interrupt (irq/irq_clr) is built with SEQDET_IRQ_EN.
module seq_detect_ctrl #(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               flush,
  seq_detect_ctrl_if.slave   bus,
  output logic               busy
`ifdef SEQDET_IRQ_EN
  ,
  output logic               irq,
  input  logic               irq_clr
`endif
);

  localparam int BC_W = $clog2(WORD_W + 1);
  localparam logic [BC_W-1:0]  BC_LOAD  = BC_W'(WORD_W);
  localparam logic [BC_W-1:0]  BC_ONE   = BC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ctrl_t;

  typedef enum logic [2:0] {
    WAITING = 3'd0,
    RCV1    = 3'd1,
    RCV11   = 3'd2,
    RCV110  = 3'd3,
    RCV1101 = 3'd4
  } det_t;

  ctrl_t             state_r, state_s;
  det_t              det_r, det_s, det_step_s;
  logic [WORD_W-1:0] shreg_r, shreg_s;
  logic [BC_W-1:0]   bcnt_r, bcnt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;

  function automatic det_t det_next(input det_t cur, input logic b);
    det_t nxt;
    case (cur)
      WAITING: nxt = b ? RCV1    : WAITING;
      RCV1:    nxt = b ? RCV11   : WAITING;
      RCV11:   nxt = b ? RCV11   : RCV110;
      RCV110:  nxt = b ? RCV1101 : WAITING;
      RCV1101: nxt = b ? RCV11   : WAITING;
      default: nxt = WAITING;
    endcase
    return nxt;
  endfunction

  // Outputs are decoded from state only; flush gating of in_ready is the one combinational input path.
  assign bus.in_ready  = (state_r == IDLE) && !flush;
  assign bus.out_valid = (state_r == DONE);
  assign bus.out_count = cnt_r;
  assign busy          = (state_r != IDLE);

  // Next-state logic for the controller, the embedded detector and the datapath.
  always_comb begin
    state_s    = state_r;
    det_s      = det_r;
    shreg_s    = shreg_r;
    bcnt_s     = bcnt_r;
    cnt_s      = cnt_r;
    det_step_s = det_next(det_r, shreg_r[WORD_W-1]);
    case (state_r)
      IDLE: begin
        if (bus.in_valid && !flush) begin
          shreg_s = bus.in_data;
          bcnt_s  = BC_LOAD;
          cnt_s   = CNT_ZERO;
          det_s   = WAITING;
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (flush) begin
          state_s = IDLE;
          det_s   = WAITING;
          cnt_s   = CNT_ZERO;
        end else begin
          det_s   = det_step_s;
          shreg_s = {shreg_r[WORD_W-2:0], 1'b0};
          bcnt_s  = bcnt_r - BC_ONE;
          // Moore output: a match is the detector entering RCV1101; count saturates.
          if ((det_step_s == RCV1101) && (cnt_r != CNT_MAX)) begin
            cnt_s = cnt_r + CNT_ONE;
          end else begin
            cnt_s = cnt_r;
          end
          if (bcnt_r == BC_ONE) begin
            state_s = DONE;
          end else begin
            state_s = SHIFT;
          end
        end
      end
      DONE: begin
        if (flush) begin
          state_s = IDLE;
          det_s   = WAITING;
          cnt_s   = CNT_ZERO;
        end else if (bus.out_ready) begin
          state_s = IDLE;
          det_s   = WAITING;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        det_s   = WAITING;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
      det_r   <= WAITING;
      shreg_r <= {WORD_W{1'b0}};
      bcnt_r  <= {BC_W{1'b0}};
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      det_r   <= det_s;
      shreg_r <= shreg_s;
      bcnt_r  <= bcnt_s;
      cnt_r   <= cnt_s;
    end
  end

`ifdef SEQDET_IRQ_EN
  logic handshake_s;
  logic irq_r;

  assign handshake_s = (state_r == DONE) && bus.out_ready;
  assign irq         = irq_r;

  // Sticky interrupt: a nonzero result handshake sets it and wins over a same-edge clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      irq_r <= 1'b0;
    end else if (handshake_s && (cnt_r != CNT_ZERO)) begin
      irq_r <= 1'b1;
    end else if (irq_clr) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_r;
    end
  end
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: substring-count model plus directed vectors.
// A second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_seq_detect_ctrl;
  localparam int WORD_W = 16;

  logic clk = 1'b0;
  logic n_rst;
  logic flush;
  logic busy, busy_sat;
`ifdef SEQDET_IRQ_EN
  logic irq, irq_sat, irq_clr;
`endif

  int n_chk = 0;
  int n_err = 0;

  seq_detect_ctrl_if #(.WORD_W(WORD_W), .CNT_W(5)) bus ();
  seq_detect_ctrl_if #(.WORD_W(WORD_W), .CNT_W(2)) sbus ();

  assign sbus.in_valid  = bus.in_valid;
  assign sbus.in_data   = bus.in_data;
  assign sbus.out_ready = bus.out_ready;

  seq_detect_ctrl #(.WORD_W(WORD_W), .CNT_W(5)) dut (
    .clk(clk), .n_rst(n_rst), .flush(flush), .bus(bus), .busy(busy)
`ifdef SEQDET_IRQ_EN
    , .irq(irq), .irq_clr(irq_clr)
`endif
  );

  seq_detect_ctrl #(.WORD_W(WORD_W), .CNT_W(2)) dut_sat (
    .clk(clk), .n_rst(n_rst), .flush(flush), .bus(sbus), .busy(busy_sat)
`ifdef SEQDET_IRQ_EN
    , .irq(irq_sat), .irq_clr(irq_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Overlapping occurrences of 1101 in the word, clipped at maxv.
  function automatic int count_1101(input logic [WORD_W-1:0] w, input int maxv);
    int n = 0;
    for (int i = WORD_W - 1; i >= 3; i--) begin
      if (w[i -: 4] == 4'b1101) n++;
    end
    return (n > maxv) ? maxv : n;
  endfunction

  // Timeline model: a word in flight for WORD_W cycles, then a result held until taken.
  logic m_run, m_done;
  int   m_left, m_cnt, m_cnt_sat;
`ifdef SEQDET_IRQ_EN
  logic m_irq;
`endif

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_run <= 1'b0; m_done <= 1'b0; m_left <= 0; m_cnt <= 0; m_cnt_sat <= 0;
    end else if (flush && (m_run || m_done)) begin
      m_run <= 1'b0; m_done <= 1'b0;
    end else if (!m_run && !m_done) begin
      if (bus.in_valid && !flush) begin
        m_run     <= 1'b1;
        m_left    <= WORD_W;
        m_cnt     <= count_1101(bus.in_data, 31);
        m_cnt_sat <= count_1101(bus.in_data, 3);
      end
    end else if (m_run) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_run  <= 1'b0;
        m_done <= 1'b1;
      end
    end else if (bus.out_ready) begin
      m_done <= 1'b0;
    end
  end

`ifdef SEQDET_IRQ_EN
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) m_irq <= 1'b0;
    else if (m_done && bus.out_ready && m_cnt != 0) m_irq <= 1'b1;
    else if (irq_clr) m_irq <= 1'b0;
  end
`endif

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("cyc_in_ready",  bus.in_ready,   !m_run && !m_done && !flush);
    check("cyc_out_valid", bus.out_valid,  m_done);
    check("cyc_busy",      busy,           m_run || m_done);
    check("cyc_sat_ready", sbus.in_ready,  !m_run && !m_done && !flush);
    check("cyc_sat_valid", sbus.out_valid, m_done);
    check("cyc_sat_busy",  busy_sat,       m_run || m_done);
    if (m_done) begin
      check("cyc_out_count", bus.out_count,  m_cnt);
      check("cyc_sat_count", sbus.out_count, m_cnt_sat);
    end
`ifdef SEQDET_IRQ_EN
    check("cyc_irq",     irq,     m_irq);
    check("cyc_sat_irq", irq_sat, m_irq);
`endif
  end

  task automatic send_word(input logic [WORD_W-1:0] w, output int waits);
    bit acc = 1'b0;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      waits = i + 1;
      if (acc) break;
    end
    check("accept_timeout", acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input int exp, input int exp_sat, input string name);
    int lat = 0;
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        found = 1'b1;
        break;
      end
      lat++;
    end
    check({name, "_found"},   found, 1);
    check({name, "_latency"}, lat, WORD_W);
    check({name, "_count"},   bus.out_count, exp);
    check({name, "_sat"},     sbus.out_count, exp_sat);
  endtask

  task automatic run_word(input logic [WORD_W-1:0] w, input int exp, input int exp_sat,
                          input string name);
    int waits;
    bus.out_ready = 1'b1;
    send_word(w, waits);
    wait_result(exp, exp_sat, name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int waits;
    n_rst = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
`ifdef SEQDET_IRQ_EN
    irq_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_count", bus.out_count, 0);
    check("rst_busy",      busy, 0);
`ifdef SEQDET_IRQ_EN
    check("rst_irq", irq, 0);
`endif
    n_rst = 1'b1;

    check("pin_D000", count_1101(16'hD000, 31), 1);
    check("pin_DB6D", count_1101(16'hDB6D, 31), 5);
    check("pin_DB6D_sat", count_1101(16'hDB6D, 3), 3);
    check("pin_FFFF", count_1101(16'hFFFF, 31), 0);
    check("pin_A000", count_1101(16'hA000, 31), 0);

    run_word(16'hD000, 1, 1, "single");
    run_word(16'hDB6D, 5, 3, "overlap");
    run_word(16'hFFFF, 0, 0, "ones");
    run_word(16'h0001, 0, 0, "boundary");
    run_word(16'hA000, 0, 0, "a000");

    // Backpressure: result held for 5 cycles with a new word waiting.
    bus.out_ready = 1'b0;
    send_word(16'hDB6D, waits);
    wait_result(5, 3, "bp");
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hD000;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_count", bus.out_count, 5);
      check("bp_hold_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send_word(16'hD000, waits);
    check("bp_accept_waits", waits, 2);
    wait_result(1, 1, "bp_next");
    @(posedge clk);
    #1;

    // Flush at bit 8 discards the word.
    send_word(16'hDB6D, waits);
    repeat (7) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready",  bus.in_ready, 1);
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_busy",      busy, 0);
    repeat (20) @(negedge clk);
    run_word(16'hD000, 1, 1, "after_flush");

    // Flush in IDLE blocks acceptance.
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hD000;
    repeat (3) begin
      @(negedge clk);
      check("flush_idle_ready", bus.in_ready, 0);
      check("flush_idle_busy",  busy, 0);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;

    // Asynchronous reset in the middle of a word.
    send_word(16'hDB6D, waits);
    repeat (5) @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_in_ready",  bus.in_ready, 1);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out_count", bus.out_count, 0);
    check("arst_busy",      busy, 0);
    @(negedge clk);
    #1;
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run_word(16'hD000, 1, 1, "after_reset");

`ifdef SEQDET_IRQ_EN
    check("irq_after_reset_word", irq, 1);
    irq_clr = 1'b1;
    @(posedge clk);
    #1;
    irq_clr = 1'b0;
    check("irq_cleared", irq, 0);
    run_word(16'hFFFF, 0, 0, "irq_zero");
    check("irq_zero_keeps_0", irq, 0);
    run_word(16'hD000, 1, 1, "irq_set");
    check("irq_set", irq, 1);
    run_word(16'hA000, 0, 0, "irq_keep");
    check("irq_zero_keeps_1", irq, 1);
    irq_clr = 1'b1;
    @(posedge clk);
    #1;
    irq_clr = 1'b0;
    check("irq_clr", irq, 0);
    bus.out_ready = 1'b0;
    send_word(16'hD000, waits);
    wait_result(1, 1, "irq_race");
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    irq_clr = 1'b1;
    @(posedge clk);
    #1;
    irq_clr = 1'b0;
    check("irq_set_wins", irq, 1);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Word-level controller for the serial "1101" Moore sequence detector. It accepts parallel words over a valid/ready handshake and serializes each word MSB-first into an embedded overlapping 1101 detector. It counts the matches that complete inside the word and returns the count over a second valid/ready handshake. It sits between a bus-side producer and a result consumer, so the bit-serial detector can be driven as a shared, sequenced resource.

## Interface
- WORD_W, 16: bits per input word, ≥4
- CNT_W, 5: match-count width; the count saturates at 2^CNT_W-1
- clk  in  1  clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous abort of the current word
- in_valid  in  1  producer has a word
- in_data  in  WORD_W  word to scan, MSB is scanned first
- in_ready  out  1  controller can accept a word
- out_valid  out  1  result available
- out_count  out  CNT_W  number of matches in the scanned word
- out_ready  in  1  consumer accepts the result
- busy  out  1  high while in SHIFT or DONE
- irq  out  1  sticky match interrupt; exists only with SEQDET_IRQ_EN
- irq_clr  in  1  clears irq; exists only with SEQDET_IRQ_EN

## Operation
- Controller FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- Detector FSM states: WAITING, RCV1, RCV11, RCV110, RCV1101. Reset state is WAITING.
- Detector transitions, written as (state: next state on bit 0 / next state on bit 1):
  - WAITING: WAITING / RCV1
  - RCV1: WAITING / RCV11
  - RCV11: RCV110 / RCV11
  - RCV110: WAITING / RCV1101
  - RCV1101: WAITING / RCV11
- Matches overlap.
- IDLE:
  - in_ready = !flush.
  - Word acceptance is in_valid && in_ready. On acceptance, load the shift register and a bit counter (WORD_W), clear the match count, force the detector to WAITING, and go to SHIFT.
- SHIFT:
  - Each cycle, present the shift-register MSB to the detector, shift left, and decrement the bit counter.
  - If the detector's next state is RCV1101, increment the count. The count saturates and does not wrap.
  - After the WORD_W-th bit, go to DONE.
- DONE:
  - out_valid=1 and out_count holds the count.
  - On out_valid && out_ready, go to IDLE.
- The detector state does not carry across words. A pattern that spans a word boundary is not counted.
- flush in SHIFT or DONE: next state is IDLE, the result is discarded, out_valid drops, and the detector is forced to WAITING. flush in IDLE blocks acceptance.
- Reset mid-operation: everything returns to reset values immediately and no result is produced.
- Reset values: in_ready=1, out_valid=0, out_count=0, busy=0, irq=0.

## Timing
- Word accepted at edge E0 → bits consumed at edges E1..E_WORD_W → out_valid=1 after E_WORD_W. Latency is WORD_W cycles from acceptance to result.
- out_count is stable while out_valid=1 and out_ready=0.
- Result handshake edge → IDLE. in_ready returns in the next cycle, so there is no same-cycle reload.
- Minimum period per word is WORD_W+2 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output except flush→in_ready.

## Configuration
- SEQDET_IRQ_EN defined:
  - irq and irq_clr exist.
  - irq is set on the result-handshake edge when out_count≠0, and stays set until the irq_clr edge.
  - If set and clear occur on the same edge, set wins.
- SEQDET_IRQ_EN undefined: the ports and the flop are absent and the behaviour is otherwise identical.

## Test plan
- Single match: in_data=0xD000 → out_valid after 16 cycles, out_count=1.
- Overlapping matches: in_data=0xDB6D → out_count=5. With CNT_W=2 the same word gives out_count=3 (saturated).
- No match and boundary isolation: send 0xFFFF, then 0x0001, then 0xA000 → out_count is 0 for every word.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, out_count stays constant, and in_ready stays 0. Acceptance happens on the first cycle out_ready=1.
- Flush and reset:
  - Pulse flush at bit 8 of 0xDB6D → no out_valid, in_ready=1 the next cycle, and a following 0xD000 gives 1.
  - Assert n_rst mid-SHIFT → all outputs go to their reset values asynchronously.
- With SEQDET_IRQ_EN:
  - A count≠0 result sets irq.
  - irq_clr on the same edge as a new nonzero result leaves irq=1.
  - A count=0 result leaves irq unchanged.
